// File: rtl/melody_seq.sv
// melody_seq: plays a melody stored in a writable step memory.
// Each step holds {half-period, beats}. A beat timer advances the steps and a
// divider produces the square-wave tone output on nota.
// Optional feature macro: MELODY_GAP_EN. When defined, the final GAP_CLKS
// cycles of each step are silent so that repeated notes sound separate.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, stop           begin playback from step 0 / abort playback
//   loop_en               restart at step 0 after the last step
//   length                number of steps to play (clamped to 2**ADDR_W)
//   wr_en, wr_addr,
//   wr_half, wr_beats     step-memory write port (half=0 is a rest, beats=0 acts as 1)
//   nota                  square-wave tone output
//   sel                   current step index
//   busy                  high while loading or playing a step
//   done                  one-cycle pulse at the natural end of a non-looping melody
module melody_seq #(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DIV_W     = 20,
   parameter int unsigned BEAT_W    = 4,
   parameter int unsigned BEAT_CLKS = 6250000,
   parameter int unsigned GAP_CLKS  = 500000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W:0]   length,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DIV_W-1:0]  wr_half,
   input  logic [BEAT_W-1:0] wr_beats,
   output logic              nota,
   output logic [ADDR_W-1:0] sel,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned LEN_W  = ADDR_W + 1;
   localparam int unsigned WORD_W = DIV_W + BEAT_W;
   localparam int unsigned TICK_W = (BEAT_CLKS > 1) ? $clog2(BEAT_CLKS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

   logic [WORD_W-1:0] mem [DEPTH];

   state_t            state;
   logic [DIV_W-1:0]  half;
   logic [DIV_W-1:0]  tone_cnt;
   logic [BEAT_W-1:0] beats;
   logic [BEAT_W-1:0] beat_cnt;
   logic [TICK_W-1:0] tick;

   logic [LEN_W-1:0]  len_eff;
   logic [BEAT_W-1:0] beats_m1;
   logic              tick_end;
   logic              step_end;
   logic              more_steps;
   logic              tone_hit;
   logic              gap_next;

   // Step memory write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= {wr_half, wr_beats};
   end

   // Step-timing helpers; a zero beat count plays as one beat.
   assign len_eff    = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
   assign beats_m1   = (beats == '0) ? '0 : beats - BEAT_W'(1);
   assign tick_end   = (tick == TICK_W'(BEAT_CLKS - 1));
   assign step_end   = tick_end && (beat_cnt == beats_m1);
   assign more_steps = ({1'b0, sel} + LEN_W'(1)) < len_eff;
   assign tone_hit   = (tone_cnt == half - DIV_W'(1));

`ifdef MELODY_GAP_EN
   // The next PLAY cycle is inside the gap when at most GAP_CLKS cycles
   // remain after it; split into whole beats plus ticks to avoid a multiply.
   localparam int unsigned GAP_LIM   = GAP_CLKS + 1;
   localparam int unsigned GAP_BEATS = GAP_LIM / BEAT_CLKS;
   localparam int unsigned GAP_REM   = GAP_LIM % BEAT_CLKS;

   logic [BEAT_W-1:0] beats_left;
   assign beats_left = beats_m1 - beat_cnt;
   assign gap_next   = (32'(beats_left) < GAP_BEATS) ||
                       ((32'(beats_left) == GAP_BEATS) &&
                        ((BEAT_CLKS - 32'(tick)) <= GAP_REM));
`else
   logic gap_unused;
   assign gap_unused = (GAP_CLKS == 0);
   assign gap_next   = 1'b0;
`endif

   // Sequencer: state, step index, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         nota     <= 1'b0;
         sel      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         half     <= '0;
         beats    <= '0;
         tone_cnt <= '0;
         beat_cnt <= '0;
         tick     <= '0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state <= S_IDLE;
            nota  <= 1'b0;
            sel   <= '0;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  nota <= 1'b0;
                  busy <= 1'b0;
                  if (start && (length != '0)) begin
                     sel   <= '0;
                     busy  <= 1'b1;
                     state <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  // Registered read of the current step; a same-cycle write sees old data.
                  {half, beats} <= mem[sel];
                  tone_cnt      <= '0;
                  beat_cnt      <= '0;
                  tick          <= '0;
                  nota          <= 1'b0;
                  state         <= S_PLAY;
               end
               S_PLAY: begin
                  if (gap_next) begin
                     nota <= 1'b0;
                  end else if (half != '0) begin
                     if (tone_hit) begin
                        nota     <= ~nota;
                        tone_cnt <= '0;
                     end else begin
                        tone_cnt <= tone_cnt + DIV_W'(1);
                     end
                  end

                  if (tick_end) begin
                     tick     <= '0;
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                  end else begin
                     tick <= tick + TICK_W'(1);
                  end

                  if (step_end) begin
                     nota <= 1'b0;
                     if (more_steps) begin
                        sel   <= sel + ADDR_W'(1);
                        state <= S_LOAD;
                     end else if (loop_en) begin
                        sel   <= '0;
                        state <= S_LOAD;
                     end else begin
                        sel   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq: randomized and directed stimulus for melody_seq, checked every
// cycle against a step-level behavioural model, plus literal tone patterns.
module tb_melody_seq;

   localparam int unsigned ADDR_W    = 3;
   localparam int unsigned DIV_W     = 8;
   localparam int unsigned BEAT_W    = 4;
   localparam int unsigned BEAT_CLKS = 4;
   localparam int unsigned GAP_CLKS  = 2;
   localparam int unsigned DEPTH     = 8;
`ifdef MELODY_GAP_EN
   localparam int GAP_N = int'(GAP_CLKS);
`else
   localparam int GAP_N = 0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              loop_en = 1'b0;
   logic [ADDR_W:0]   length = '0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DIV_W-1:0]  wr_half = '0;
   logic [BEAT_W-1:0] wr_beats = '0;
   logic              nota;
   logic [ADDR_W-1:0] sel;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_errors = 0;
   bit run_cmp  = 1'b0;

   always #5 clk = ~clk;

   melody_seq #(
      .ADDR_W(ADDR_W), .DIV_W(DIV_W), .BEAT_W(BEAT_W),
      .BEAT_CLKS(BEAT_CLKS), .GAP_CLKS(GAP_CLKS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
      .length(length), .wr_en(wr_en), .wr_addr(wr_addr), .wr_half(wr_half),
      .wr_beats(wr_beats), .nota(nota), .sel(sel), .busy(busy), .done(done)
   );

   // Behavioural model: which step is playing and how far into it we are.
   logic [DIV_W+BEAT_W-1:0] m_mem [DEPTH];
   bit m_busy = 0, m_loading = 0, m_done = 0;
   int m_sel = 0, m_k = 0, m_dur = 1, m_half = 0, m_beats = 0, m_len = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_loading = 0; m_done = 0;
         m_sel = 0; m_k = 0; m_dur = 1; m_half = 0;
      end else begin
         m_done = 0;
         if (stop) begin
            m_busy = 0; m_loading = 0; m_sel = 0;
         end else if (!m_busy) begin
            if (start && length != 0) begin
               m_busy = 1; m_loading = 1; m_sel = 0;
            end
         end else if (m_loading) begin
            m_half    = int'(m_mem[m_sel][DIV_W+BEAT_W-1:BEAT_W]);
            m_beats   = int'(m_mem[m_sel][BEAT_W-1:0]);
            m_dur     = ((m_beats == 0) ? 1 : m_beats) * int'(BEAT_CLKS);
            m_k       = 0;
            m_loading = 0;
         end else if (m_k == m_dur - 1) begin
            m_len = (int'(length) > int'(DEPTH)) ? int'(DEPTH) : int'(length);
            if (m_sel + 1 < m_len) begin
               m_sel = m_sel + 1; m_loading = 1;
            end else if (loop_en) begin
               m_sel = 0; m_loading = 1;
            end else begin
               m_busy = 0; m_sel = 0; m_done = 1;
            end
         end else begin
            m_k = m_k + 1;
         end
         if (wr_en) m_mem[wr_addr] = {wr_half, wr_beats};
      end
   end

   // Tone level k cycles into a step: toggles every half cycles, silent in the gap.
   function automatic bit exp_nota();
      if (!m_busy || m_loading || m_half == 0) return 1'b0;
      if (m_k + GAP_N >= m_dur) return 1'b0;
      return ((m_k / m_half) % 2) != 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && run_cmp) begin
         chk("nota", 32'(nota), 32'(exp_nota()));
         chk("sel",  32'(sel),  32'(m_sel));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic wr(input int a, input int h, input int b);
      wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_half = DIV_W'(h); wr_beats = BEAT_W'(b);
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (done) seen = 1;
         else cyc();
      end
      chk(name, 32'(seen), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] nv;
      logic [3:0] n4;
      logic [7:0] exp8;
      logic [3:0] exp4;
      int dn;

      repeat (2) cyc();
      chk("rst_nota", 32'(nota), 32'd0);
      chk("rst_sel",  32'(sel),  32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(posedge clk); #2 rst = 1'b0;
      cyc();
      run_cmp = 1'b1;

      for (int a = 2; a < int'(DEPTH); a++)
         wr(a, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      wr(0, 2, 2);
      wr(1, 0, 1);

      // Basic play: tone step then rest step.
      length = 4'd2; loop_en = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      chk("basic_busy_load", 32'(busy), 32'd1);
      chk("basic_nota_load", 32'(nota), 32'd0);
      cyc();
      for (int i = 0; i < 8; i++) begin nv[i] = nota; cyc(); end
`ifdef MELODY_GAP_EN
      exp8 = 8'b0000_1100;
`else
      exp8 = 8'b1100_1100;
`endif
      chk("basic_tone", 32'(nv), 32'(exp8));
      chk("basic_sel_load1", 32'(sel), 32'd1);
      chk("basic_busy_load1", 32'(busy), 32'd1);
      cyc();
      n4 = '0;
      for (int i = 0; i < 4; i++) begin n4[i] = nota; cyc(); end
      chk("basic_rest", 32'(n4), 32'd0);
      chk("basic_done", 32'(done), 32'd1);
      chk("basic_busy_end", 32'(busy), 32'd0);
      chk("basic_sel_end", 32'(sel), 32'd0);
      cyc();
      chk("basic_done_once", 32'(done), 32'd0);

      // Zero beats plays as one beat.
      wr(0, 1, 0);
      length = 4'd1;
      start = 1'b1; cyc(); start = 1'b0;
      cyc();
      for (int i = 0; i < 4; i++) begin n4[i] = nota; cyc(); end
`ifdef MELODY_GAP_EN
      exp4 = 4'b0010;
`else
      exp4 = 4'b1010;
`endif
      chk("beats0_tone", 32'(n4), 32'(exp4));
      chk("beats0_done", 32'(done), 32'd1);

      // Loop mode, then let it finish.
      wr(0, 2, 2);
      length = 4'd2; loop_en = 1'b1;
      start = 1'b1; cyc(); start = 1'b0;
      dn = 0;
      repeat (40) begin dn += int'(done); cyc(); end
      chk("loop_no_done", 32'(dn), 32'd0);
      loop_en = 1'b0;
      wait_done("loop_end_done");
      cyc();

      // Stop together with start, then start with zero length.
      start = 1'b1; cyc(); start = 1'b0;
      repeat (4) cyc();
      stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_nota", 32'(nota), 32'd0);
      chk("stop_done", 32'(done), 32'd0);
      length = 4'd0;
      start = 1'b1; cyc(); start = 1'b0; cyc();
      chk("len0_busy", 32'(busy), 32'd0);
      length = 4'd2;

      // Rewrite step 1 while step 0 plays.
      start = 1'b1; cyc(); start = 1'b0;
      cyc();
      wr(1, 3, 1);
      repeat (7) cyc();
      chk("wdp_sel", 32'(sel), 32'd1);
      cyc();
      for (int i = 0; i < 4; i++) begin n4[i] = nota; cyc(); end
`ifdef MELODY_GAP_EN
      exp4 = 4'b0000;
`else
      exp4 = 4'b1000;
`endif
      chk("wdp_tone", 32'(n4), 32'(exp4));
      wait_done("wdp_done");
      cyc();

      // Random stimulus against the model.
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 31) == 0) loop_en = ~loop_en;
         if (!m_busy && $urandom_range(0, 3) == 0) length = 4'($urandom_range(0, 15));
         wr_en    = ($urandom_range(0, 2) == 0);
         wr_addr  = 3'($urandom_range(0, 7));
         wr_half  = 8'($urandom_range(0, 5));
         wr_beats = 4'($urandom_range(0, 3));
         cyc();
      end
      start = 1'b0; wr_en = 1'b0; loop_en = 1'b0;
      stop = 1'b1; cyc(); stop = 1'b0;

      // Asynchronous reset in the middle of a step.
      wr(0, 1, 3);
      length = 4'd1;
      start = 1'b1; cyc(); start = 1'b0;
      repeat (4) cyc();
      chk("arst_pre_busy", 32'(busy), 32'd1);
      @(posedge clk); #2 rst = 1'b1; #1;
      chk("arst_nota", 32'(nota), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_sel",  32'(sel),  32'd0);
      @(posedge clk); #2 rst = 1'b0;
      cyc(); cyc();
      chk("arst_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/melody_seq.md
Name: melody_seq

Overview:
- Parametrised successor to the fixed-tune note player. It plays a melody stored in a writable step memory.
- Each step holds a tone half-period (in clk cycles) and a duration (in beats). A beat timer advances the steps.
- A divider produces the square-wave note output that drives the speaker pin.
- Adds start/stop, a loop mode, a programmable melody length, a run-time loadable tune and rests, none of which the fixed-mux generation has.

Parameters:
- ADDR_W, 5, step address width; memory depth is 2**ADDR_W.
- DIV_W, 20, half-period field width (clk cycles).
- BEAT_W, 4, duration field width (beats per step).
- BEAT_CLKS, 6250000, clk cycles per beat (125 ms at 50 MHz).
- GAP_CLKS, 500000, articulation silence length. Used only with MELODY_GAP_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin playback from step 0 (level, sampled each clk).
- stop  in  1  abort playback.
- loop_en  in  1  1 = restart at step 0 after the last step.
- length  in  ADDR_W+1  number of steps to play, 0..2**ADDR_W.
- wr_en  in  1  step-memory write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_half  in  DIV_W  half-period to store; 0 = rest.
- wr_beats  in  BEAT_W  beats to store; 0 is treated as 1.
- nota  out  1  square-wave tone output.
- sel  out  ADDR_W  current step index.
- busy  out  1  high in LOAD/PLAY.
- done  out  1  one-cycle pulse at natural end of a non-looping melody.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE, nota=0, sel=0, busy=0, done=0, all counters 0. Memory contents are undefined (not cleared).
- Memory: 2**ADDR_W x (DIV_W+BEAT_W).
  - Synchronous write when wr_en=1, in any state.
  - Registered read at address sel.
  - Read and write to the same address in the same cycle: the read returns the old data.
  - A write to a step that is not yet loaded takes effect when that step loads.
- States: IDLE, LOAD, PLAY.
- IDLE:
  - nota=0, busy=0.
  - start=1 and length!=0 -> sel=0, go to LOAD next cycle.
  - start with length=0 is ignored.
- LOAD (exactly 1 cycle):
  - Latch half and beats from the memory read.
  - Clear the tone counter and the duration counter; nota=0. Go to PLAY.
- PLAY:
  - Tone:
    - half!=0: tone counter increments each clk. When count == half-1, toggle nota and clear the counter. half=1 toggles every clk.
    - half=0: nota held 0 (rest).
  - Duration: counts max(beats,1)*BEAT_CLKS clk cycles in PLAY, then the step ends. Use a beat counter plus a beat-tick counter; no multiplier.
- Step end:
  - sel < length-1 -> sel+1, go to LOAD.
  - sel == length-1 and loop_en=1 -> sel=0, go to LOAD.
  - sel == length-1 and loop_en=0 -> done=1 for one cycle, go to IDLE, sel=0.
- Step timing: from the first PLAY cycle of one step to the first PLAY cycle of the next = duration + 1 (the LOAD cycle).
- stop=1 in any state -> IDLE next cycle, nota=0, sel=0, no done pulse.
- stop and start both high: stop wins.
- start while busy is ignored.
- length and loop_en are sampled at each step end, so changing them mid-play affects only the current end-of-step decision.
- length greater than 2**ADDR_W is clamped to 2**ADDR_W.
- All outputs are registered.

Optional Feature:
- Macro: MELODY_GAP_EN.
- Defined:
  - During the final GAP_CLKS cycles of each PLAY step, nota is forced to 0 and the tone counter is held. This makes repeated notes audibly separate.
  - If the step duration is <= GAP_CLKS, the whole step is silent.
- Undefined: no gap, tone continuous for the full step; GAP_CLKS unused.

Test Plan:
Bench parameters: ADDR_W=3, DIV_W=8, BEAT_W=4, BEAT_CLKS=4, GAP_CLKS=2.
- Basic play: write step0={half=2,beats=2}, step1={half=0,beats=1}; length=2, pulse start.
  -> busy rises next cycle, then LOAD, then PLAY.
  -> nota toggles every 2 clk for 8 clk.
  -> LOAD, then nota held 0 for 4 clk.
  -> done pulses once; busy=0; sel=0.
- Beats zero: step0={half=1,beats=0}, length=1.
  -> plays for 4 clk, nota toggling every clk; then done.
- Loop: same tune as basic play with loop_en=1, run 40 clk.
  -> sel sequence 0,1,0,1...; no done pulse.
  -> clear loop_en -> done pulses at the next end of step 1.
- Stop and start: assert stop mid-step0 together with start.
  -> IDLE next cycle, nota=0, done=0.
  -> start with length=0 leaves busy=0.
- Write during play: while step0 plays, write step1={half=3,beats=1}.
  -> step1 plays with nota period 6 clk.
- Async reset mid-PLAY: assert rst between clk edges.
  -> nota=0, busy=0, sel=0 immediately, without waiting for a clk edge.
- MELODY_GAP_EN defined: basic-play tune.
  -> nota=0 during the last 2 clk of step0.
  -> step1 duration (4 clk) is fully silent.
